// File: rtl/jb_block_request_pkg.sv
// Shared pipeline definitions for jump/branch stall handshaking: opcodes, kinds, FSM states.
// No logic; zero latency, no backpressure.
package jb_block_request_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        JB_NONE   = 2'd0,
        JB_JAL    = 2'd1,
        JB_JALR   = 2'd2,
        JB_BRANCH = 2'd3
    } jb_kind_t;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
    localparam logic [1:0] S_HOLD     = 2'd3;

endpackage

// File: rtl/jb_block_request_opcode_decode.sv
// Classifies an RV32 opcode as JAL, JALR, BRANCH or none.
// Purely combinational, zero latency; no flow control.
module jb_opcode_decode
    import jb_block_request_pkg::*;
(
    input  logic [6:0] opcode,
    output jb_kind_t   kind
);

    always_comb begin
        kind = JB_NONE;
        case (opcode)
            OP_JAL:    kind = JB_JAL;
            OP_JALR:   kind = JB_JALR;
            OP_BRANCH: kind = JB_BRANCH;
            default:   kind = JB_NONE;
        endcase
    end

endmodule

// File: rtl/jb_block_request.sv
// Initiator of the jump/branch stall: one-cycle block request, then tracks JBPCSrc to completion.
// block follows the trigger by 1 cycle; ID inputs are ignored while busy (pipeline frozen, nothing queued).
module jb_block_request
    import jb_block_request_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 4,
    parameter int HOLD_MAX    = 8,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             instr_valid,
    input  logic [XLEN-1:0]  instr,
    input  logic [XLEN-1:0]  pc_id,
    input  logic             JBPCSrc,
    output logic             block,
    output logic             busy,
    output logic [1:0]       jb_kind,
    output logic [XLEN-1:0]  jb_pc,
    output logic             err,
    output logic [CNT_W-1:0] jb_count
);

    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    logic [1:0]        state;
    logic              suppress;
    logic [ACK_W-1:0]  ack_tmr;
    logic [HOLD_W-1:0] hold_tmr;
    logic [HOLD_W-1:0] hold_nxt;
    jb_kind_t          dec_kind;
    logic              is_cti;
    logic              trigger;
    logic              unused_instr_hi;

    jb_opcode_decode u_decode (
        .opcode (instr[6:0]),
        .kind   (dec_kind)
    );

    assign unused_instr_hi = ^instr[XLEN-1:7];
    assign is_cti   = (dec_kind != JB_NONE);
    assign hold_nxt = hold_tmr + 1'b1;

    // The frozen instruction re-presents the same PC after the stall; don't request twice for it.
    assign trigger = (state == S_IDLE) && instr_valid && is_cti
                   && !(suppress && (pc_id == jb_pc));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            block    <= 1'b0;
            busy     <= 1'b0;
            jb_kind  <= 2'd0;
            jb_pc    <= '0;
            err      <= 1'b0;
            jb_count <= '0;
            suppress <= 1'b0;
            ack_tmr  <= '0;
            hold_tmr <= '0;
        end else begin
            block <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && (!is_cti || (pc_id != jb_pc)))
                        suppress <= 1'b0;
                    if (trigger) begin
                        state   <= S_REQ;
                        block   <= 1'b1;
                        busy    <= 1'b1;
                        jb_pc   <= pc_id;
                        jb_kind <= dec_kind;
                        if (jb_count != {CNT_W{1'b1}})
                            jb_count <= jb_count + 1'b1;
                    end
                end
                S_REQ: begin
                    if (JBPCSrc) begin
                        state    <= S_HOLD;
                        hold_tmr <= '0;
                    end else begin
                        state   <= S_WAIT_ACK;
                        ack_tmr <= ACK_W'(1);
                    end
                end
                S_WAIT_ACK: begin
                    // ack_tmr counts cycles since block; ACK_TIMEOUT is the last cycle an ack is accepted.
                    if (JBPCSrc) begin
                        state    <= S_HOLD;
                        hold_tmr <= '0;
                    end else if (ack_tmr == ACK_W'(ACK_TIMEOUT)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ack_tmr <= ack_tmr + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!JBPCSrc) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        suppress <= 1'b1;
                    end else if (hold_nxt == HOLD_W'(HOLD_MAX)) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                        suppress <= 1'b1;
                    end else begin
                        hold_tmr <= hold_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jb_block_request.sv
// Randomized and directed bench for jb_block_request against a timing-arithmetic reference model.
module tb_jb_block_request;

    localparam int XLEN        = 32;
    localparam int ACK_TIMEOUT = 4;
    localparam int HOLD_MAX    = 8;
    localparam int CNT_W       = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             instr_valid;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc_id;
    logic             JBPCSrc;
    logic             block;
    logic             busy;
    logic [1:0]       jb_kind;
    logic [XLEN-1:0]  jb_pc;
    logic             err;
    logic [CNT_W-1:0] jb_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic             exp_err;
    int               exp_count;
    logic [1:0]       exp_kind;
    logic [XLEN-1:0]  exp_pc;

    jb_block_request #(
        .XLEN        (XLEN),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .HOLD_MAX    (HOLD_MAX),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc_id       (pc_id),
        .JBPCSrc     (JBPCSrc),
        .block       (block),
        .busy        (busy),
        .jb_kind     (jb_kind),
        .jb_pc       (jb_pc),
        .err         (err),
        .jb_count    (jb_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] ref_kind(input logic [31:0] ins);
        case (ins[6:0])
            7'h6F:   return 2'd1;
            7'h67:   return 2'd2;
            7'h63:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic reset_dut();
        @(negedge CLK);
        RST = 1'b1; instr_valid = 1'b0; instr = '0; pc_id = '0; JBPCSrc = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        exp_err = 1'b0; exp_count = 0; exp_kind = 2'd0; exp_pc = '0;
    endtask

    // One request at the current (idle) negedge. d = cycles after block until JBPCSrc rises
    // (beyond ACK_TIMEOUT means never), h = cycles JBPCSrc stays high.
    task automatic run_txn(input logic [31:0] ins, input logic [31:0] pc,
                           input int d, input int h, input bit noise);
        int  end_off;
        bit  err_now;
        err_now = 1'b0;
        if (d > ACK_TIMEOUT) begin
            end_off = ACK_TIMEOUT + 1; err_now = 1'b1;
        end else if (h - 1 >= HOLD_MAX) begin
            end_off = d + 1 + HOLD_MAX; err_now = 1'b1;
        end else begin
            end_off = d + h + 1;
        end
        exp_pc   = pc;
        exp_kind = ref_kind(ins);
        if (exp_count < (1 << CNT_W) - 1) exp_count++;

        instr_valid = 1'b1; instr = ins; pc_id = pc; JBPCSrc = 1'b0;
        for (int off = 0; off <= end_off; off++) begin
            @(negedge CLK);
            n_checks++;
            if (block !== (off == 0)) $display("FAIL txn_block off=%0d got=%b want=%b", off, block, off == 0);
            else n_pass++;
            n_checks++;
            if (busy !== (off < end_off)) $display("FAIL txn_busy off=%0d got=%b want=%b", off, busy, off < end_off);
            else n_pass++;
            if (off == 0) begin
                n_checks++;
                if (jb_kind !== exp_kind) $display("FAIL txn_kind got=%0d want=%0d", jb_kind, exp_kind);
                else n_pass++;
                n_checks++;
                if (jb_pc !== exp_pc) $display("FAIL txn_pc got=%h want=%h", jb_pc, exp_pc);
                else n_pass++;
                n_checks++;
                if (jb_count !== CNT_W'(exp_count)) $display("FAIL txn_count got=%0d want=%0d", jb_count, exp_count);
                else n_pass++;
            end
            if (off < end_off) begin
                JBPCSrc = (d <= ACK_TIMEOUT) && (off >= d) && (off < d + h);
                instr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                instr = 32'h0000006F | ($urandom & 32'hFFFF_F000);
                pc_id = $urandom & 32'hFFFF_FFFC;
            end else begin
                instr_valid = 1'b0; JBPCSrc = 1'b0;
            end
        end
        exp_err = exp_err | err_now;
        n_checks++;
        if (err !== exp_err) $display("FAIL txn_err got=%b want=%b", err, exp_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (block !== 1'b0) $display("FAIL rst_block got=%b want=0", block); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (jb_kind !== 2'd0) $display("FAIL rst_kind got=%0d want=0", jb_kind); else n_pass++;
        n_checks++; if (jb_pc !== '0) $display("FAIL rst_pc got=%h want=0", jb_pc); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err got=%b want=0", err); else n_pass++;
        n_checks++; if (jb_count !== '0) $display("FAIL rst_count got=%0d want=0", jb_count); else n_pass++;
    endtask

    task automatic test_jal_basic();
        reset_dut();
        run_txn(32'h0000006F, 32'h40, 1, 3, 1'b0);
    endtask

    task automatic test_suppress();
        instr_valid = 1'b1; instr = 32'h0000006F; pc_id = 32'h40;
        repeat (3) begin
            @(negedge CLK);
            n_checks++;
            if (block !== 1'b0 || busy !== 1'b0) $display("FAIL suppress_retrigger block=%b busy=%b want 0/0", block, busy);
            else n_pass++;
        end
        instr = 32'h00000013; pc_id = 32'h44;
        @(negedge CLK);
        n_checks++;
        if (block !== 1'b0) $display("FAIL suppress_addi block=%b want=0", block); else n_pass++;
        run_txn(32'h0000006F, 32'h40, 0, 2, 1'b0);
    endtask

    task automatic test_ack_timeout();
        run_txn(32'h00000063, 32'h80, ACK_TIMEOUT + 3, 0, 1'b1);
        run_txn(32'h00000067, 32'h90, 0, 2, 1'b0);
    endtask

    task automatic test_hold_timeout();
        reset_dut();
        run_txn(32'hFE0008E3, 32'h100, 0, 20, 1'b1);
    endtask

    task automatic test_non_jump();
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr = (i % 2 == 0) ? 32'h00000033 : 32'h00000003;
            pc_id = $urandom & 32'hFFFF_FFFC;
            @(negedge CLK);
            n_checks++;
            if (block !== 1'b0 || busy !== 1'b0) $display("FAIL nonjump_idle i=%0d block=%b busy=%b want 0/0", i, block, busy);
            else n_pass++;
        end
        instr_valid = 1'b0;
        n_checks++;
        if (jb_count !== '0) $display("FAIL nonjump_count got=%0d want=0", jb_count); else n_pass++;
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 17; i++)
            run_txn((i % 2 == 0) ? 32'h0000006F : 32'h00000067, 32'h200 + 32'(4 * i), 0, 1, 1'b0);
        n_checks++;
        if (jb_count !== 4'hF) $display("FAIL sat_count got=%h want=f", jb_count); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        instr_valid = 1'b1; instr = 32'h0000006F; pc_id = 32'h300;
        @(negedge CLK);
        instr_valid = 1'b0; JBPCSrc = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midhold_busy got=%b want=1", busy); else n_pass++;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_err = 1'b0; exp_count = 0; exp_kind = 2'd0; exp_pc = '0;
        n_checks++;
        if ({block, busy, jb_kind, jb_pc, err, jb_count} !== '0)
            $display("FAIL midhold_reset got block=%b busy=%b kind=%0d pc=%h err=%b cnt=%0d want all 0",
                     block, busy, jb_kind, jb_pc, err, jb_count);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (block !== 1'b0 || busy !== 1'b0) $display("FAIL midhold_after block=%b busy=%b want 0/0", block, busy);
        else n_pass++;
        JBPCSrc = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] ins, pc;
        int d, h;
        logic [6:0] ops [3];
        logic [6:0] nops [3];
        ops[0] = 7'h6F; ops[1] = 7'h67; ops[2] = 7'h63;
        nops[0] = 7'h13; nops[1] = 7'h33; nops[2] = 7'h03;
        reset_dut();
        for (int t = 0; t < 40; t++) begin
            ins = ($urandom & 32'hFFFF_FF80) | {25'd0, ops[$urandom_range(0, 2)]};
            pc  = $urandom & 32'hFFFF_FFFC;
            d   = $urandom_range(0, ACK_TIMEOUT + 2);
            h   = $urandom_range(1, HOLD_MAX + 3);
            run_txn(ins, pc, d, h, 1'b1);
            if (d <= ACK_TIMEOUT) begin
                instr_valid = 1'b1; instr = ins; pc_id = pc;
                @(negedge CLK);
                n_checks++;
                if (block !== 1'b0 || busy !== 1'b0) $display("FAIL rand_suppress t=%0d block=%b busy=%b want 0/0", t, block, busy);
                else n_pass++;
            end
            instr_valid = 1'b1;
            instr = ($urandom & 32'hFFFF_FF80) | {25'd0, nops[$urandom_range(0, 2)]};
            pc_id = pc;
            @(negedge CLK);
            instr_valid = 1'b0;
            n_checks++;
            if (block !== 1'b0) $display("FAIL rand_nontrigger t=%0d block=%b want=0", t, block);
            else n_pass++;
        end
    endtask

    initial begin
        RST = 1'b1; instr_valid = 1'b0; instr = '0; pc_id = '0; JBPCSrc = 1'b0;
        test_reset();
        test_jal_basic();
        test_suppress();
        test_ack_timeout();
        test_hold_timeout();
        test_non_jump();
        test_saturation();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
